// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART definitions: baud table, FSM states, port default
package uart_defs;

   localparam int          CLK_HZ_DEFAULT    = 50_000_000;
   localparam logic [15:0] DATA_PORT_DEFAULT = 16'h0000;
   localparam int          K_W               = 18;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   // Bit period in clocks, rounded to nearest.
   function automatic logic [K_W-1:0] baud_k(input int clk_hz, input int rate);
      int q;
      q = (clk_hz + rate / 2) / rate;
      return q[K_W-1:0];
   endfunction

endpackage

// File: rtl/uart_baud_dec.sv
// rtl/uart_baud_dec.sv - baud code to bit-period count decoder
module uart_baud_dec
   import uart_defs::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
   input  logic [3:0]     baud,
   output logic [K_W-1:0] k
);

   always_comb begin
      case (baud)
         4'd0:    k = baud_k(CLK_HZ, 300);
         4'd1:    k = baud_k(CLK_HZ, 1200);
         4'd2:    k = baud_k(CLK_HZ, 2400);
         4'd3:    k = baud_k(CLK_HZ, 4800);
         4'd4:    k = baud_k(CLK_HZ, 9600);
         4'd5:    k = baud_k(CLK_HZ, 19200);
         4'd6:    k = baud_k(CLK_HZ, 38400);
         4'd7:    k = baud_k(CLK_HZ, 57600);
         4'd8:    k = baud_k(CLK_HZ, 115200);
         4'd9:    k = baud_k(CLK_HZ, 230400);
         4'd10:   k = baud_k(CLK_HZ, 460800);
         default: k = baud_k(CLK_HZ, 921600);
      endcase
   end

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART receiver: synchroniser, frame FSM, receive register
module uart_rx_engine
   import uart_defs::*;
#(
   parameter int          CLK_HZ    = CLK_HZ_DEFAULT,
   parameter logic [15:0] DATA_PORT = DATA_PORT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic        eight,
   input  logic        pen,
   input  logic        ohel,
   input  logic [3:0]  baud,
   input  logic        read_strobe,
   input  logic [15:0] port_id,
   output logic [7:0]  rx_data,
   output logic        rxrdy,
   output logic        perr,
   output logic        ferr,
   output logic        ovf
);

   logic [K_W-1:0] k_in;

   uart_baud_dec #(.CLK_HZ(CLK_HZ)) u_baud_dec (
      .baud (baud),
      .k    (k_in)
   );

   rx_state_e      state_q, state_d;
   logic           sync1_q, rx_s_q;
   logic [K_W-1:0] cnt_q, cnt_d;
   logic [K_W-1:0] k_q, k_d;
   logic           eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
   logic [7:0]     sh_q, sh_d;
   logic [2:0]     bits_q, bits_d;
   logic           par_q, par_d;
   logic           perr_pend_q, perr_pend_d;
   logic           armed_q, armed_d;
   logic           upd_q, upd_d;
   logic           stop_q, stop_d;
   logic [7:0]     rx_data_q, rx_data_d;
   logic           rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
   logic           expire, host_rd;
   logic [2:0]     last_bit;

   assign expire   = (cnt_q == '0);
   assign host_rd  = read_strobe && (port_id == DATA_PORT);
   assign last_bit = eight_q ? 3'd7 : 3'd6;

   always_comb begin
      state_d     = state_q;
      cnt_d       = expire ? cnt_q : cnt_q - 1'b1;
      k_d         = k_q;
      eight_d     = eight_q;
      pen_d       = pen_q;
      ohel_d      = ohel_q;
      sh_d        = sh_q;
      bits_d      = bits_q;
      par_d       = par_q;
      perr_pend_d = perr_pend_q;
      armed_d     = armed_q;
      upd_d       = 1'b0;
      stop_d      = stop_q;
      rx_data_d   = rx_data_q;
      rxrdy_d     = rxrdy_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      ovf_d       = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (rx_s_q) armed_d = 1'b1;
            if (!rx_s_q && armed_q) begin
               state_d     = ST_START;
               cnt_d       = k_in >> 1;
               k_d         = k_in;
               eight_d     = eight;
               pen_d       = pen;
               ohel_d      = ohel;
               par_d       = ohel;
               bits_d      = '0;
               perr_pend_d = 1'b0;
            end
         end
         ST_START: begin
            if (expire) begin
               if (rx_s_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
                  cnt_d   = k_q - 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (expire) begin
               sh_d   = {rx_s_q, sh_q[7:1]};
               par_d  = par_q ^ rx_s_q;
               bits_d = bits_q + 1'b1;
               cnt_d  = k_q - 1'b1;
               if (bits_q == last_bit) state_d = pen_q ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (expire) begin
               perr_pend_d = par_q ^ rx_s_q;
               cnt_d       = k_q - 1'b1;
               state_d     = ST_STOP;
            end
         end
         ST_STOP: begin
            if (expire) begin
               stop_d  = rx_s_q;
               upd_d   = 1'b1;
               state_d = ST_IDLE;
               if (!rx_s_q) armed_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Stop sample lands in the register one cycle later; a coincident read loses.
      if (upd_q) begin
         rx_data_d = eight_q ? sh_q : {1'b0, sh_q[7:1]};
         perr_d    = perr_pend_q;
         ferr_d    = !stop_q;
         ovf_d     = rxrdy_q && !host_rd;
         rxrdy_d   = 1'b1;
      end else if (host_rd) begin
         rxrdy_d = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         cnt_q       <= '0;
         k_q         <= '0;
         eight_q     <= 1'b0;
         pen_q       <= 1'b0;
         ohel_q      <= 1'b0;
         sh_q        <= '0;
         bits_q      <= '0;
         par_q       <= 1'b0;
         perr_pend_q <= 1'b0;
         armed_q     <= 1'b1;
         upd_q       <= 1'b0;
         stop_q      <= 1'b1;
         rx_data_q   <= '0;
         rxrdy_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= rx;
         rx_s_q      <= sync1_q;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         eight_q     <= eight_d;
         pen_q       <= pen_d;
         ohel_q      <= ohel_d;
         sh_q        <= sh_d;
         bits_q      <= bits_d;
         par_q       <= par_d;
         perr_pend_q <= perr_pend_d;
         armed_q     <= armed_d;
         upd_q       <= upd_d;
         stop_q      <= stop_d;
         rx_data_q   <= rx_data_d;
         rxrdy_q     <= rxrdy_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovf_q       <= ovf_d;
      end
   end

   assign rx_data = rx_data_q;
   assign rxrdy   = rxrdy_q;
   assign perr    = perr_q;
   assign ferr    = ferr_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - scoreboard bench for uart_rx_engine
module tb_uart_rx_engine;

   localparam logic [15:0] PORT = 16'h0042;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic        eight = 1'b1, pen = 1'b0, ohel = 1'b0;
   logic [3:0]  baud = 4'd11;
   logic        read_strobe = 1'b0;
   logic [15:0] port_id = 16'h0000;
   logic [7:0]  rx_data;
   logic        rxrdy, perr, ferr, ovf;

   int cyc = 0;
   int n_pass = 0, n_total = 0;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       ovf;
      int         cyc;
   } exp_t;
   exp_t sb_q[$];

   uart_rx_engine #(.CLK_HZ(50_000_000), .DATA_PORT(PORT)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .eight       (eight),
      .pen         (pen),
      .ohel        (ohel),
      .baud        (baud),
      .read_strobe (read_strobe),
      .port_id     (port_id),
      .rx_data     (rx_data),
      .rxrdy       (rxrdy),
      .perr        (perr),
      .ferr        (ferr),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Monitor: any change of the register while rxrdy is set is an update event.
   initial begin
      logic [11:0] prev, cur;
      exp_t        e;
      int          nev;
      prev = '0;
      nev  = 0;
      forever begin
         @(negedge clk);
         cur = {rxrdy, rx_data, perr, ferr, ovf};
         if (!reset && rxrdy && cur != prev) begin
            nev++;
            if (sb_q.size() == 0) begin
               check($sformatf("ev%0d_unexpected_update", nev), 1, 0);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("ev%0d_rx_data", nev), int'(rx_data), int'(e.data));
               check($sformatf("ev%0d_perr", nev), int'(perr), int'(e.perr));
               check($sformatf("ev%0d_ferr", nev), int'(ferr), int'(e.ferr));
               check($sformatf("ev%0d_ovf", nev), int'(ovf), int'(e.ovf));
               check($sformatf("ev%0d_cycle", nev), cyc, e.cyc);
            end
         end
         prev = cur;
      end
   end

   // Called at a negedge; the start bit is first sampled by the next posedge (c0).
   task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                             input bit par_bit, input bit stop_bit, input int k,
                             input bit rd_upd, input bit expect_upd, input logic [7:0] e_data,
                             input bit e_perr, input bit e_ferr, input bit e_ovf);
      bit   seq[12];
      int   nb, c0, off;
      exp_t e;
      nb = 0;
      seq[nb] = 1'b0; nb++;
      for (int i = 0; i < nbits; i++) begin
         seq[nb] = data[i]; nb++;
      end
      if (has_par) begin
         seq[nb] = par_bit; nb++;
      end
      seq[nb] = stop_bit; nb++;
      c0  = cyc + 1;
      off = 3 + k / 2 + (1 + nbits + int'(has_par)) * k + 1;
      if (expect_upd) begin
         e.data = e_data; e.perr = e_perr; e.ferr = e_ferr; e.ovf = e_ovf; e.cyc = c0 + off;
         sb_q.push_back(e);
      end
      for (int b = 0; b < nb; b++) begin
         rx = seq[b];
         for (int j = 0; j < k; j++) begin
            @(negedge clk);
            if (rd_upd && cyc == c0 + off - 1) begin
               read_strobe = 1'b1;
               port_id     = PORT;
            end else if (rd_upd && cyc == c0 + off) begin
               read_strobe = 1'b0;
               port_id     = 16'h0000;
            end
         end
      end
   endtask

   task automatic read_port(input logic [15:0] p);
      read_strobe = 1'b1;
      port_id     = p;
      @(negedge clk);
      read_strobe = 1'b0;
      port_id     = 16'h0000;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_data"}, int'(rx_data), 0);
      check({tag, "_rxrdy"}, int'(rxrdy), 0);
      check({tag, "_perr"}, int'(perr), 0);
      check({tag, "_ferr"}, int'(ferr), 0);
      check({tag, "_ovf"}, int'(ovf), 0);
   endtask

   initial begin
      exp_t e;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      idle(20);

      // 8N1 0x55, rxrdy 517 cycles after c0; wrong port leaves it, data port clears it.
      send_frame(8'h55, 8, 0, 0, 1, 54, 0, 1, 8'h55, 0, 0, 0);
      idle(10);
      read_port(16'h0000);
      check("wrong_port_rxrdy", int'(rxrdy), 1);
      read_port(PORT);
      check("read_rxrdy", int'(rxrdy), 0);
      check("read_keeps_data", int'(rx_data), 8'h55);

      // 7O1: 0x41 has two ones, so the odd parity bit must be 1.
      eight = 1'b0; pen = 1'b1; ohel = 1'b1;
      send_frame(8'h41, 7, 1, 1, 1, 54, 0, 1, 8'h41, 0, 0, 0);
      idle(10);
      read_port(PORT);
      send_frame(8'h41, 7, 1, 0, 1, 54, 0, 1, 8'h41, 1, 0, 0);
      idle(10);
      read_port(PORT);
      eight = 1'b1; pen = 1'b0; ohel = 1'b0;

      // Framing error, then break held for five frame times.
      send_frame(8'hAA, 8, 0, 0, 0, 54, 0, 1, 8'hAA, 0, 1, 0);
      idle(60);
      read_port(PORT);
      e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b1; e.ovf = 1'b0; e.cyc = cyc + 1 + 517;
      sb_q.push_back(e);
      rx = 1'b0;
      repeat (2700) @(negedge clk);
      check("break_queue_drained", sb_q.size(), 0);
      idle(100);
      read_port(PORT);
      idle(20);

      // Overrun, then a read coinciding with the update.
      send_frame(8'h12, 8, 0, 0, 1, 54, 0, 1, 8'h12, 0, 0, 0);
      send_frame(8'h34, 8, 0, 0, 1, 54, 0, 1, 8'h34, 0, 0, 1);
      send_frame(8'h56, 8, 0, 0, 1, 54, 1, 1, 8'h56, 0, 0, 0);
      idle(10);
      check("simul_read_rxrdy", int'(rxrdy), 1);
      read_port(PORT);
      check("post_read_rxrdy", int'(rxrdy), 0);

      // 10-cycle glitch must not start a frame.
      rx = 1'b0;
      repeat (10) @(negedge clk);
      idle(200);
      check("glitch_rxrdy", int'(rxrdy), 0);

      // Reset mid-frame, then a clean 0xC3.
      send_frame(8'h9C, 8, 0, 0, 1, 54, 0, 1, 8'h9C, 0, 0, 0);
      idle(10);
      rx = 1'b0;
      repeat (150) @(negedge clk);
      reset = 1'b1;
      rx    = 1'b1;
      @(negedge clk);
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(20);
      send_frame(8'hC3, 8, 0, 0, 1, 54, 0, 1, 8'hC3, 0, 0, 0);
      idle(10);
      read_port(PORT);

      // Rate change mid-frame only affects the following frame.
      fork
         send_frame(8'h3C, 8, 0, 0, 1, 54, 0, 1, 8'h3C, 0, 0, 0);
         begin
            repeat (100) @(negedge clk);
            baud = 4'd8;
         end
      join
      idle(10);
      read_port(PORT);
      idle(10);
      send_frame(8'hE1, 8, 0, 0, 1, 434, 0, 1, 8'hE1, 0, 0, 0);
      idle(20);

      check("final_queue_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Receive half of the UART: deserialises the asynchronous `rx` line into bytes, using the same `eight`/`pen`/`ohel`/`baud` configuration inputs as the transmit path. Each completed frame is held in a receive register with its parity, framing and overrun status. The host port (`read_strobe`/`port_id`) consumes the register. The block sits beside the transmitter inside the UART top and shares its 50 MHz clock and baud table.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency; the baud table is derived from it.
- `DATA_PORT`, default 16'h0000: `port_id` value whose read consumes the receive register.
- `clk`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input; idles high; asynchronous to `clk`.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `pen`  in  1  parity enable.
- `ohel`  in  1  parity sense: 1 = odd, 0 = even.
- `baud`  in  4  rate select: 0 = 300, 1 = 1200, 2 = 2400, 3 = 4800, 4 = 9600, 5 = 19200, 6 = 38400, 7 = 57600, 8 = 115200, 9 = 230400, 10 = 460800, 11 = 921600; codes 12–15 select 921600.
- `read_strobe`  in  1  host read qualifier; one cycle wide.
- `port_id`  in  16  host port address.
- `rx_data`  out  8  last received character; bit 7 is 0 in 7-bit mode.
- `rxrdy`  out  1  receive register holds an unread character.
- `perr`  out  1  parity error for the character in `rx_data`.
- `ferr`  out  1  framing error (stop bit sampled 0) for `rx_data`.
- `ovf`  out  1  a character was overwritten before it was read.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, giving `rx_s`. All logic uses `rx_s` only.
- **Baud counts:** bit period `K` = round(`CLK_HZ`/rate), in an 18-bit counter. At 50 MHz this gives 166667, 41667, 20833, 10417, 5208, 2604, 1302, 868, 434, 217, 109, 54. The half period is `K`>>1.
- **Configuration capture:** `eight`, `pen`, `ohel` and `K` are captured on leaving IDLE. Changes made mid-frame take effect on the next frame.
- **Frame format:** start bit (0), then N = 7 or 8 data bits LSB first, then the parity bit if `pen`=1, then 1 stop bit.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** if `rx_s`=0 and `armed`=1, go to START with counter = half period.
  - **START:** at counter expiry, sample `rx_s`. If 1 (false start), go back to IDLE. If 0, go to DATA with counter = `K`.
  - **DATA:** sample one bit at each expiry. After N samples go to PARITY if `pen`=1, otherwise to STOP.
  - **PARITY:** sample one bit at expiry, then go to STOP.
  - **STOP:** sample at expiry, update the receive register, go to IDLE.
- **Parity check:** the expected parity bit = XOR of the N data bits, XORed with `ohel`. `perr` = expected bit ≠ sampled bit. `perr` = 0 when `pen`=0.
- **Break suppression (`armed`):** cleared when STOP samples 0. Set again once `rx_s`=1 is seen in IDLE. A held-low line therefore produces exactly one frame with `ferr`.
- **Receive register update (at stop sample):**
  - `rx_data`, `perr` and `ferr` are overwritten.
  - `ovf` = old `rxrdy` AND NOT a same-cycle read.
  - `rxrdy` = 1.
- **Host read:** `read_strobe`=1 with `port_id`=`DATA_PORT` clears `rxrdy` and `ovf`. It does not change `rx_data`, `perr` or `ferr`.
- **Read and update in the same cycle:** the update wins for `rxrdy` (stays 1), and `ovf` = 0.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; `armed` = 1; synchroniser flops = 1. Reset asserted mid-frame aborts the frame with no register update.
- **Latency:** let c0 be the first `clk` edge that samples `rx`=0. The stop bit is sampled at c0 + 3 + `K`/2 + (1 + N + `pen`)·`K`. `rxrdy` and the other outputs change on the following edge.
  - Example, `K`=54, 8N1: `rxrdy` rises 517 cycles after c0.
- **Glitch rejection:** a low pulse shorter than `K`/2 − 3 cycles is rejected as a false start; nothing is updated.
- **Next frame:** the receiver returns to IDLE half a bit before the nominal stop-bit end. A new start bit can follow the stop bit immediately.
- **Register timing:** all outputs are registered; there is no combinational path from input to output.

## Structure
- **Shared package `uart_defs`** (also used by the transmitter):
  - baud-count constants / `CLK_HZ`-derived table
  - FSM state encodings
  - `DATA_PORT` default
- **Sub-module `uart_baud_dec`:** decodes `baud` into `K` and is shared with the transmitter. The bit-period counter, shift register, parity accumulator and FSM stay in `uart_rx_engine`.

## Test plan
- **8N1 basic receive:** `baud`=11, `eight`=1, `pen`=0, serialise 0x55 → `rx_data`=0x55 and `rxrdy`=1 exactly 517 cycles after the start edge; `perr`=`ferr`=`ovf`=0. A data-port read clears `rxrdy`.
- **7O1 parity:** `eight`=0, `pen`=1, `ohel`=1.
  - Send 0x41 with parity bit 1 → `rx_data`=0x41, `perr`=0.
  - Resend with parity bit 0 → `perr`=1.
- **Framing and break:** send 0xAA with stop bit 0 → `ferr`=1. Hold `rx` low for 5 frame times → exactly one `rxrdy` event.
- **Overrun and simultaneous read:**
  - Send 0x12 then 0x34 with no read → `rx_data`=0x34, `ovf`=1.
  - Repeat with the read landing on the stop-sample cycle → `ovf`=0, `rxrdy`=1.
- **False start and reset:**
  - A 10-cycle low glitch at `baud`=11 → no update.
  - Assert `reset` mid-frame → all outputs 0; the next clean frame 0xC3 is received correctly.
- **Mid-frame rate change:** change `baud` from 11 to 8 during a frame → the current frame still decodes at 921600; the next frame decodes at 115200 (`K`=434).
